// File: rtl/weight_loader_18_16_2_64_pkg.sv
// rtl/weight_loader_18_16_2_64_pkg.sv - shared sizes and state enumeration for the weight loader
//
// Purpose: geometry of the CLSTM weight RAM banks (18-bit elements, 16 lanes,
// 2 banks of 64 words) and the loader FSM state type.
// Ports: none (package).
package weight_loader_18_16_2_64_pkg;

  localparam int DATA_WIDTH  = 18;
  localparam int LANES       = 16;
  localparam int ADDR_WIDTH  = 6;
  localparam int WORD_WIDTH  = DATA_WIDTH * LANES;              // 288
  localparam int NUM_BANKS   = 2;
  localparam int WORDS_TOTAL = NUM_BANKS * (1 << ADDR_WIDTH);   // 128

  localparam int LANE_CNT_W  = $clog2(LANES);
  localparam int WORD_CNT_W  = $clog2(WORDS_TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/weight_loader_18_16_2_64_packer.sv
// rtl/weight_loader_18_16_2_64_packer.sv - lane packer building one 288-bit RAM word
//
// Purpose: holds the pack register and lane counter. Each load_i writes data_i
// into the lane selected by the counter and advances it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     clears the pack register and lane counter (start of a load)
//   load_i      accept data_i into the current lane
//   data_i      18-bit weight element
//   full_o      the current lane is the last one; a load now completes the word
//   word_o      packed word including data_i in the current lane, so the
//               completing element can be captured in the same edge
module weight_lane_packer
  import weight_loader_18_16_2_64_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic [WORD_WIDTH-1:0] word_o
);

  logic [LANE_CNT_W-1:0] lane_q;
  logic [WORD_WIDTH-1:0] pack_q;

  always_comb begin
    word_o = pack_q;
    word_o[lane_q*DATA_WIDTH +: DATA_WIDTH] = data_i;
  end

  assign full_o = (lane_q == LANE_CNT_W'(LANES - 1));

  // LANES is a power of two, so the lane counter wraps to 0 by itself after
  // the last lane and the next word starts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
      pack_q <= '0;
    end else if (load_i) begin
      lane_q <= lane_q + LANE_CNT_W'(1);
      pack_q <= word_o;
    end
  end

endmodule

// File: rtl/weight_loader_18_16_2_64.sv
// rtl/weight_loader_18_16_2_64.sv - streaming writer filling the two CLSTM weight RAM banks
//
// Purpose: accepts 18-bit weight elements on a valid/ready stream, packs 16
// per word and writes word k to bank k%2 at address k/2, 128 words per load.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN (running element sum).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    begin a full load (sampled in IDLE only)
//   in_data/in_valid/in_ready element stream
//   wr_en_x/wr_addr_x/wr_data_x bank x write port (x = 0, 1)
//   busy                     load in progress (through the done cycle)
//   done                     one-cycle pulse after the final write
//   checksum                 sign-extended element sum, or 0 without the macro
module weight_loader_18_16_2_64
  import weight_loader_18_16_2_64_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en_0,
  output logic                  wr_en_1,
  output logic [ADDR_WIDTH-1:0] wr_addr_0,
  output logic [ADDR_WIDTH-1:0] wr_addr_1,
  output logic [WORD_WIDTH-1:0] wr_data_0,
  output logic [WORD_WIDTH-1:0] wr_data_1,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum
);

  loader_state_e         state_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_en_0_q, wr_en_1_q;
  logic [ADDR_WIDTH-1:0] wr_addr_0_q, wr_addr_1_q;
  logic [WORD_WIDTH-1:0] wr_data_0_q, wr_data_1_q;

  logic                  start_acc;
  logic                  hs;
  logic                  pk_full;
  logic [WORD_WIDTH-1:0] pk_word;

  assign start_acc = (state_q == ST_IDLE) && start;
  // in_ready_q is high exactly in FILL, so this is the only accept condition.
  assign hs        = in_valid && in_ready_q;

  weight_lane_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (start_acc),
    .load_i  (hs),
    .data_i  (in_data),
    .full_o  (pk_full),
    .word_o  (pk_word)
  );

  // Write strobes and data are captured on the edge that accepts lane 15, so
  // the write port is valid during the WRITE cycle and the RAM latches it on
  // the edge that ends WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_0_q   <= 1'b0;
      wr_en_1_q   <= 1'b0;
      wr_addr_0_q <= '0;
      wr_addr_1_q <= '0;
      wr_data_0_q <= '0;
      wr_data_1_q <= '0;
    end else begin
      wr_en_0_q   <= 1'b0;
      wr_en_1_q   <= 1'b0;
      wr_addr_0_q <= '0;
      wr_addr_1_q <= '0;
      wr_data_0_q <= '0;
      wr_data_1_q <= '0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_FILL;
            word_cnt_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_FILL: begin
          if (hs && pk_full) begin
            state_q    <= ST_WRITE;
            in_ready_q <= 1'b0;
            if (word_cnt_q[0] == 1'b0) begin
              wr_en_0_q   <= 1'b1;
              wr_addr_0_q <= word_cnt_q[WORD_CNT_W-1:1];
              wr_data_0_q <= pk_word;
            end else begin
              wr_en_1_q   <= 1'b1;
              wr_addr_1_q <= word_cnt_q[WORD_CNT_W-1:1];
              wr_data_1_q <= pk_word;
            end
          end
        end
        ST_WRITE: begin
          word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
          if (word_cnt_q == WORD_CNT_W'(WORDS_TOTAL - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ST_FILL;
            in_ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en_0   = wr_en_0_q;
  assign wr_en_1   = wr_en_1_q;
  assign wr_addr_0 = wr_addr_0_q;
  assign wr_addr_1 = wr_addr_1_q;
  assign wr_data_0 = wr_data_0_q;
  assign wr_data_1 = wr_data_1_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Holds after done so the controller can read it until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (hs) begin
      checksum_q <= checksum_q + {{(32-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_weight_loader_18_16_2_64.sv
// tb/tb_weight_loader_18_16_2_64.sv - scoreboard bench for the weight loader
module tb_weight_loader_18_16_2_64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [17:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         wr_en_0, wr_en_1;
  logic [5:0]   wr_addr_0, wr_addr_1;
  logic [287:0] wr_data_0, wr_data_1;
  logic         busy, done;
  logic [31:0]  checksum;

  weight_loader_18_16_2_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en_0   (wr_en_0),
    .wr_en_1   (wr_en_1),
    .wr_addr_0 (wr_addr_0),
    .wr_addr_1 (wr_addr_1),
    .wr_data_0 (wr_data_0),
    .wr_data_1 (wr_data_1),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         bank;
    logic [5:0]   addr;
    logic [287:0] data;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  logic [287:0] ram0 [64];
  logic [287:0] ram1 [64];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           done_lat = 0;
  int           wr_cnt = 0;
  bit           done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] elem(input int mode, input int i);
    if (mode == 0) return 18'(i);
    return 18'h3FFFF;
  endfunction

  function automatic logic [287:0] word_of(input int mode, input int k);
    logic [287:0] w;
    for (int l = 0; l < 16; l++) w[l*18 +: 18] = elem(mode, 16*k + l);
    return w;
  endfunction

  task automatic push_words(input int mode, input int nwords);
    wr_t e;
    for (int k = 0; k < nwords; k++) begin
      e.bank = k[0];
      e.addr = 6'(k / 2);
      e.data = word_of(mode, k);
      exp_q.push_back(e);
    end
  endtask

  // Write-port monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_0 || wr_en_1) begin
        wr_cnt++;
        check("wr_one_bank", {wr_en_0, wr_en_1}, 2'b01 << wr_en_0);
        check("wr_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_bank", wr_en_1, mon_e.bank);
          if (wr_en_1) begin
            check("wr_addr_1", wr_addr_1, mon_e.addr);
            check("wr_data_1", wr_data_1, mon_e.data);
            check("idle_bank0", {wr_addr_0, wr_data_0}, 0);
          end else begin
            check("wr_addr_0", wr_addr_0, mon_e.addr);
            check("wr_data_0", wr_data_0, mon_e.data);
            check("idle_bank1", {wr_addr_1, wr_data_1}, 0);
          end
        end
        if (wr_en_1) ram1[wr_addr_1] = wr_data_1;
        else         ram0[wr_addr_0] = wr_data_0;
      end
      if (done && !done_seen) begin
        done_seen = 1;
        done_lat  = cyc - start_cyc;
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic do_start();
    done_seen = 0;
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic run_load(input int mode, input bit gaps, input int start_at, input int stop_after);
    int  i = 0;
    int  budget = 0;
    bit  hs;
    while (i < stop_after && budget < 20000) begin
      @(negedge clk);
      in_data  = elem(mode, i);
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      start    = (i == start_at);
      hs       = in_valid && in_ready;
      @(posedge clk);
      if (hs) i++;
      budget++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_in_budget", budget < 20000, 1);
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done_seen && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", done_seen, 1);
    @(negedge clk);
    check("done_pulse_fall", {done, busy}, 2'b00);
  endtask

  initial begin
    int wr_before;
    logic [31:0] exp_cs;

    // Reset and idle behaviour
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1, busy, done, checksum}, 0);
    check("reset_data", wr_data_0 | wr_data_1, 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("idle_no_ready", {in_ready, busy, wr_en_0, wr_en_1}, 0);
    end
    in_valid = 1'b0;

    // Full load, index data, valid held high
    push_words(0, 128);
    wr_before = wr_cnt;
    do_start();
    run_load(0, 1'b0, -1, 2048);
    wait_done();
    check("done_latency", done_lat, 2177);
    check("wr_count_full", wr_cnt - wr_before, 128);
    check("queue_drained_1", exp_q.size(), 0);
    check("b0_a0", ram0[0], word_of(0, 0));
    check("b1_a0", ram1[0], word_of(0, 1));
    check("b1_a63", ram1[63], word_of(0, 127));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    exp_cs = 32'd2096128;
`else
    exp_cs = 32'd0;
`endif
    check("checksum_index", checksum, exp_cs);

    // Same data with random valid gaps
    for (int a = 0; a < 64; a++) begin
      ram0[a] = '0;
      ram1[a] = '0;
    end
    push_words(0, 128);
    wr_before = wr_cnt;
    do_start();
    run_load(0, 1'b1, -1, 2048);
    wait_done();
    check("wr_count_gaps", wr_cnt - wr_before, 128);
    check("queue_drained_2", exp_q.size(), 0);
    for (int a = 0; a < 64; a++) begin
      check("ram0_gaps", ram0[a], word_of(0, 2*a));
      check("ram1_gaps", ram1[a], word_of(0, 2*a + 1));
    end

    // start pulsed mid-FILL is ignored
    push_words(0, 128);
    do_start();
    run_load(0, 1'b0, 5, 2048);
    wait_done();
    check("queue_drained_3", exp_q.size(), 0);

    // Reset after 20 accepted elements
    push_words(0, 1);
    wr_before = wr_cnt;
    do_start();
    run_load(0, 1'b0, -1, 20);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {in_ready, wr_en_0, wr_en_1, wr_addr_0, wr_addr_1, busy, done, checksum}, 0);
    check("rst_data", wr_data_0 | wr_data_1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_wr_count", wr_cnt - wr_before, 1);
    check("queue_drained_4", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("post_rst_idle", {in_ready, busy}, 0);

    // Restart after reset, all -1 elements
    push_words(1, 128);
    do_start();
    run_load(1, 1'b0, -1, 2048);
    wait_done();
    check("queue_drained_5", exp_q.size(), 0);
    check("b0_a0_neg", ram0[0], word_of(1, 0));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    exp_cs = 32'hFFFFF800;
`else
    exp_cs = 32'd0;
`endif
    check("checksum_neg", checksum, exp_cs);
    repeat (4) @(negedge clk);
    check("checksum_hold", checksum, exp_cs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
